mem_master: RTL and testbench
=============================

// Module: mem_master
// PURPOSE
//  Initiator for the single-port memory bus (addr/rw/en/data_i/data_o).
//  Accepts read/write commands on a valid/ready command channel and drives exactly one memory access per command.
//  Returns read data on a valid/ready response channel.
//  Sits between a bus agent/sequencer and the memory; one transaction in flight at a time.
// PARAMETERS
//  ADDR_WIDTH  2  memory address width; 2**ADDR_WIDTH words
//  DATA_WIDTH  8  memory data word width
// PORTS
//  clk         in   1           clock, all logic on rising edge
//  rst         in   1           asynchronous, active-low reset
//  cmd_valid   in   1           command present
//  cmd_ready   out  1           command accepted when cmd_valid&&cmd_ready at clk edge
//  cmd_rw      in   1           1=write, 0=read
//  cmd_addr    in   ADDR_WIDTH  command address
//  cmd_wdata   in   DATA_WIDTH  write data (ignored for reads)
//  rsp_valid   out  1           response present
//  rsp_ready   in   1           response consumed when rsp_valid&&rsp_ready at clk edge
//  rsp_rdata   out  DATA_WIDTH  read data (0 for write acks)
//  rsp_is_wr   out  1           response is a write ack (only with MEM_MASTER_WRACK_EN; else tied 0)
//  busy        out  1           state != IDLE
//  mem_addr_o  out  ADDR_WIDTH  to memory addr_i
//  mem_rw_o    out  1           to memory rw_i
//  mem_en_o    out  1           to memory en_i
//  mem_data_o  out  DATA_WIDTH  to memory data_i
//  mem_data_i  in   DATA_WIDTH  from memory data_o (registered, valid 1 cycle after en&&!rw edge)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; cmd_ready=1 after release; rsp_valid=0, rsp_rdata=0, rsp_is_wr=0;
//   mem_en_o=0, mem_rw_o=0, mem_addr_o=0, mem_data_o=0; busy=0. In-flight txn dropped, no response.
//  All outputs decoded from registers only; no combinational path cmd_*/rsp_ready -> any output.
//  FSM: IDLE -> ISSUE -> (read) CAPT -> RESP -> IDLE; (write) ISSUE -> IDLE.
//   IDLE : cmd_ready=1. On accept, latch rw/addr/wdata into mem_*_o regs -> ISSUE.
//   ISSUE: mem_en_o=1 for exactly one cycle; mem_addr_o/rw_o/data_o stable. Write -> IDLE; read -> CAPT.
//   CAPT : mem_en_o=0; at edge rsp_rdata<=mem_data_i, rsp_valid<=1 -> RESP.
//   RESP : rsp_valid held, rsp_rdata stable until rsp_ready; on handshake rsp_valid<=0 -> IDLE.
//  cmd_ready=0 in every state but IDLE; cmd_valid while busy is backpressured, not dropped.
//  Latency (accept at edge N): read rsp_valid high after edge N+2; write mem access at edge N+1,
//   next cmd_ready after edge N+1 (write throughput 1 per 2 cycles).
//  rsp_ready held low: FSM stays in RESP indefinitely, memory untouched (mem_en_o=0).
//  rsp_ready asserted before rsp_valid: no effect.
//  Address max (2**ADDR_WIDTH-1) legal; no wrap or auto-increment; widths pass through unmodified.
//  mem_en_o never high for two consecutive cycles; never high outside ISSUE.
// CONFIGURATION
//  `MEM_MASTER_WRACK_EN defined: write path ISSUE -> RESP with rsp_valid=1, rsp_is_wr=1, rsp_rdata=0;
//   write completes only on rsp handshake (ack after edge N+1).
//  Not defined: writes return no response; rsp_is_wr tied 0; write ISSUE -> IDLE.
// TESTING (ADDR_WIDTH=2, DATA_WIDTH=8, behavioural memory model attached)
//  1 Reset: rst=0 mid-read (in CAPT) -> all outputs 0 async, no rsp; after release cmd_ready=1, busy=0.
//  2 Write 0xA5 @3 then read @3 -> one mem_en_o pulse each; rsp_rdata=0xA5 after edge N+2 of read accept.
//  3 Write 0x11,0x22,0x33,0x44 @0..3, read back @3,0,2,1 -> 0x44,0x11,0x33,0x22 in order.
//  4 Read @1 with rsp_ready=0 for 10 cycles, cmd_valid held -> rsp_valid/rsp_rdata stable,
//    cmd_ready=0, mem_en_o=0 throughout; second cmd accepted in cycle after rsp handshake.
//  5 Back-to-back writes, cmd_valid always 1 -> accept every 2nd cycle, mem_en_o never 2 cycles high.
//  6 WRACK_EN: write 0xFF @2 -> rsp_valid=1, rsp_is_wr=1, rsp_rdata=0; without macro no rsp_valid.

Source files
------------

// File: rtl/mem_master.sv
// mem_master: single-transaction initiator for the single-port memory bus.
//
// Takes read/write commands on a valid/ready command channel, performs exactly
// one memory access per command, and returns read data on a valid/ready
// response channel. Only one transaction is in flight at any time.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous, active-low reset
//   cmd_valid  : command present            cmd_ready : command accepted on handshake
//   cmd_rw     : 1 = write, 0 = read        cmd_addr  : command address
//   cmd_wdata  : write data (ignored for reads)
//   rsp_valid  : response present           rsp_ready : response consumed on handshake
//   rsp_rdata  : read data (0 for write acks)
//   rsp_is_wr  : response is a write ack (tied 0 unless MEM_MASTER_WRACK_EN)
//   busy       : FSM not idle
//   mem_addr_o, mem_rw_o, mem_en_o, mem_data_o : drive the memory inputs
//   mem_data_i : registered memory read data, valid one cycle after a read access
//
// Build option
//   MEM_MASTER_WRACK_EN : when defined, every write returns a write-ack response
//                         (rsp_is_wr=1, rsp_rdata=0) and completes on its handshake.
//
// All outputs come straight from registers (state or data flops); nothing on the
// command or response inputs reaches an output combinationally.

module mem_master #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_is_wr,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_rw_o,
  output logic                  mem_en_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   accept;

  assign accept = cmd_valid && cmd_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: begin
        if (mem_rw_o) begin
`ifdef MEM_MASTER_WRACK_EN
          state_nxt = RESP;
`else
          state_nxt = IDLE;
`endif
        end else begin
          state_nxt = CAPT;
        end
      end
      CAPT:  state_nxt = RESP;
      RESP:  if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cmd_ready is its own flop (rather than a decode of state) so that it reads
  // 0 while reset is asserted and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd_ready <= (state_nxt == IDLE);
    end
  end

  // Command capture: these registers drive the memory bus directly and stay
  // stable from accept through the ISSUE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr_o <= '0;
      mem_rw_o   <= 1'b0;
      mem_data_o <= '0;
    end else if (accept) begin
      mem_addr_o <= cmd_addr;
      mem_rw_o   <= cmd_rw;
      mem_data_o <= cmd_wdata;
    end
  end

  // Response data: the memory presents read data one cycle after the access,
  // which is the CAPT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_rdata <= '0;
    end else if (state == CAPT) begin
      rsp_rdata <= mem_data_i;
`ifdef MEM_MASTER_WRACK_EN
    end else if (state == ISSUE && mem_rw_o) begin
      rsp_rdata <= '0;
`endif
    end
  end

`ifdef MEM_MASTER_WRACK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_is_wr <= 1'b0;
    end else if (state == CAPT) begin
      rsp_is_wr <= 1'b0;
    end else if (state == ISSUE && mem_rw_o) begin
      rsp_is_wr <= 1'b1;
    end
  end
`else
  assign rsp_is_wr = 1'b0;
`endif

  assign busy      = (state != IDLE);
  assign mem_en_o  = (state == ISSUE);
  assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_mem_master.sv
module tb_mem_master;

  localparam int AW = 2;
  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_rw;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_is_wr;
  logic          busy;
  logic [AW-1:0] mem_addr_o;
  logic          mem_rw_o;
  logic          mem_en_o;
  logic [DW-1:0] mem_data_o;
  logic [DW-1:0] mem_data_i;

  mem_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_is_wr(rsp_is_wr), .busy(busy),
    .mem_addr_o(mem_addr_o), .mem_rw_o(mem_rw_o), .mem_en_o(mem_en_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port memory with registered read data.
  logic [DW-1:0] mem_model [4];
  always @(posedge clk) begin
    if (mem_en_o && mem_rw_o)  mem_model[mem_addr_o] <= mem_data_o;
    if (mem_en_o && !mem_rw_o) mem_data_i <= mem_model[mem_addr_o];
  end

  typedef struct {
    logic [DW-1:0] rdata;
    logic          is_wr;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;
  int   en_count  = 0;
  int   en_double = 0;
  logic prev_en   = 1'b0;
  int   accept_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: response scoreboard plus mem_en_o pulse tracking.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (mem_en_o) en_count++;
      if (mem_en_o && prev_en) en_double++;
      prev_en = mem_en_o;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_rdata), 32'hDEAD);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          check("rsp_is_wr", 32'(rsp_is_wr), 32'(e.is_wr));
        end
      end
    end else begin
      prev_en = 1'b0;
    end
  end

  // Present a command and return #1 after the edge that accepts it.
  task automatic issue(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_wdata = d;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      $display("FAIL cmd_accept_timeout: cmd_ready=%0b after %0d cycles, expected 1", cmd_ready, n);
      n_vec++; n_miss++;
    end
    @(posedge clk);
    accept_cyc = cyc;
    #1 cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
`ifdef MEM_MASTER_WRACK_EN
    rsp_t e;
    e.rdata = '0; e.is_wr = 1'b1;
    exp_q.push_back(e);
`endif
    issue(1'b1, a, d);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    rsp_t e;
    e.rdata = exp; e.is_wr = 1'b0;
    exp_q.push_back(e);
    issue(1'b0, a, 8'h00);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int   e0;
    int   prev_acc;
    logic stall_ok_v, stall_ok_d, stall_ok_r, stall_ok_e;
    logic saw_rsp;
    rsp_t e;

    rst = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) mem_model[i] = '0;
    mem_data_i = '0;

    // Reset state
    #2;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_mem_en",    32'(mem_en_o),  32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("rel_cmd_ready", 32'(cmd_ready), 32'd1);

    // Write 0xA5 @3, read @3: one enable pulse each, data after edge N+2
    e0 = en_count;
    do_write(2'd3, 8'hA5);
    check("wr_mem_en_n", 32'(mem_en_o), 32'd1);
    check("wr_mem_addr", 32'(mem_addr_o), 32'd3);
    check("wr_mem_data", 32'(mem_data_o), 32'hA5);
    @(posedge clk); #1;
`ifndef MEM_MASTER_WRACK_EN
    check("wr_ready_n1", 32'(cmd_ready), 32'd1);
`endif
    wait_idle();
    do_read(2'd3, 8'hA5);
    @(posedge clk); #1;
    check("rd_valid_n1", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("rd_valid_n2", 32'(rsp_valid), 32'd1);
    check("rd_data_n2",  32'(rsp_rdata), 32'hA5);
    wait_idle();
    check("en_pulses_2", 32'(en_count - e0), 32'd2);

    // Reset while a read sits in CAPT
    issue(1'b0, 2'd3, 8'h77);
    @(posedge clk); #1;
    check("capt_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("arst_busy",      32'(busy),       32'd0);
    check("arst_cmd_ready", 32'(cmd_ready),  32'd0);
    check("arst_rsp_valid", 32'(rsp_valid),  32'd0);
    check("arst_rsp_rdata", 32'(rsp_rdata),  32'd0);
    check("arst_mem_addr",  32'(mem_addr_o), 32'd0);
    check("arst_mem_data",  32'(mem_data_o), 32'd0);
    check("arst_mem_en",    32'(mem_en_o),   32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    saw_rsp = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (rsp_valid) saw_rsp = 1'b1;
    end
    check("arst_no_rsp",   32'(saw_rsp),   32'd0);
    check("arst_ready",    32'(cmd_ready), 32'd1);
    check("arst_busy_rel", 32'(busy),      32'd0);

    // Fill all addresses and read back out of order
    do_write(2'd0, 8'h11);
    do_write(2'd1, 8'h22);
    do_write(2'd2, 8'h33);
    do_write(2'd3, 8'h44);
    do_read(2'd3, 8'h44);
    do_read(2'd0, 8'h11);
    do_read(2'd2, 8'h33);
    do_read(2'd1, 8'h22);
    wait_idle();

    // Response stall with a second command held on the command channel
    rsp_ready = 1'b0;
    do_read(2'd1, 8'h22);
    e.rdata = 8'h11; e.is_wr = 1'b0;
    exp_q.push_back(e);
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 2'd0; cmd_wdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    stall_ok_v = 1'b1; stall_ok_d = 1'b1; stall_ok_r = 1'b1; stall_ok_e = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid) stall_ok_v = 1'b0;
      if (rsp_rdata !== 8'h22) stall_ok_d = 1'b0;
      if (cmd_ready) stall_ok_r = 1'b0;
      if (mem_en_o) stall_ok_e = 1'b0;
    end
    check("stall_rsp_valid", 32'(stall_ok_v), 32'd1);
    check("stall_rsp_rdata", 32'(stall_ok_d), 32'd1);
    check("stall_cmd_ready", 32'(stall_ok_r), 32'd1);
    check("stall_mem_en",    32'(stall_ok_e), 32'd1);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("post_hs_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    check("post_hs_accept", 32'(busy), 32'd1);
    cmd_valid = 1'b0;
    wait_idle();

    // Back-to-back writes with cmd_valid held
    prev_acc = -1;
    do_write(2'd0, 8'h5A);
    prev_acc = accept_cyc;
    do_write(2'd1, 8'hC3);
    check("b2b_gap1", 32'(accept_cyc - prev_acc), 32'd2);
    prev_acc = accept_cyc;
    do_write(2'd2, 8'h0F);
    check("b2b_gap2", 32'(accept_cyc - prev_acc), 32'd2);
    prev_acc = accept_cyc;
    do_write(2'd3, 8'hF0);
    check("b2b_gap3", 32'(accept_cyc - prev_acc), 32'd2);
    do_read(2'd0, 8'h5A);
    do_read(2'd1, 8'hC3);
    do_read(2'd2, 8'h0F);
    do_read(2'd3, 8'hF0);
    wait_idle();

    // Write 0xFF @2: ack only when write-ack responses are built in
    rsp_ready = 1'b0;
    do_write(2'd2, 8'hFF);
    @(posedge clk); #1;
`ifdef MEM_MASTER_WRACK_EN
    check("wrack_valid", 32'(rsp_valid), 32'd1);
    check("wrack_is_wr", 32'(rsp_is_wr), 32'd1);
    check("wrack_rdata", 32'(rsp_rdata), 32'd0);
`else
    check("nowrack_valid", 32'(rsp_valid), 32'd0);
    check("nowrack_is_wr", 32'(rsp_is_wr), 32'd0);
`endif
    rsp_ready = 1'b1;
    do_read(2'd2, 8'hFF);
    wait_idle();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("en_never_double", 32'(en_double), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
